// File: rtl/cpu6502_status_pkg.sv
// ============================================================================
// Package : cpu6502_status_pkg
// Purpose : Shared definitions for the 6502 status register block: flag bit
//           indices, interrupt vector addresses, the mask of bits that are
//           physically stored in P, the request FSM state type and the
//           ALU flag merge helper.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu6502_status_pkg;

  // Flag positions inside P
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_I = 2;
  localparam int FLAG_D = 3;
  localparam int FLAG_B = 4;
  localparam int FLAG_U = 5;
  localparam int FLAG_V = 6;
  localparam int FLAG_N = 7;

  // Interrupt vectors, consumed by the sequencer alongside int_nmi
  localparam logic [15:0] VEC_NMI = 16'hFFFA;
  localparam logic [15:0] VEC_IRQ = 16'hFFFE;

  // B and the unused bit only exist in the pushed image, never in P
  localparam logic [7:0] P_STORED_MASK = 8'hCF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } int_state_t;

  // Apply an ALU {N,Z,C,V} result under a per-flag enable mask.
  function automatic logic [7:0] alu_merge(input logic [7:0] p,
                                           input logic [3:0] nzcv,
                                           input logic [3:0] mask);
    logic [7:0] r;
    r = p;
    if (mask[3]) r[FLAG_N] = nzcv[3];
    if (mask[2]) r[FLAG_Z] = nzcv[2];
    if (mask[1]) r[FLAG_C] = nzcv[1];
    if (mask[0]) r[FLAG_V] = nzcv[0];
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu6502_nmi_detect.sv
// ============================================================================
// Module  : cpu6502_nmi_detect
// Purpose : NMI synchroniser, falling-edge detector and pending latch.
// Ports   : clk     in  system clock
//           reset   in  asynchronous active-low reset
//           nmi     in  active-low NMI pin
//           clr     in  clear pending (NMI entry acknowledged)
//           pending out NMI edge seen and not yet serviced
// Params  : NMI_SYNC 1 = 2-flop synchroniser ahead of edge detect,
//                    0 = raw pin into the edge-detect register only
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module cpu6502_nmi_detect #(
  parameter int NMI_SYNC = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic nmi,
  input  logic clr,
  output logic pending
);

  logic nmi_s;
  logic nmi_prev;
  logic pend_q;
  logic fall;

  generate
    if (NMI_SYNC != 0) begin : g_sync
      logic [1:0] sync_q;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], nmi};
      end
      assign nmi_s = sync_q[1];
    end else begin : g_nosync
      assign nmi_s = nmi;
    end
  endgenerate

  assign fall = nmi_prev & ~nmi_s;

  // A new edge wins over a simultaneous clear so it is never lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nmi_prev <= 1'b1;
      pend_q   <= 1'b0;
    end else begin
      nmi_prev <= nmi_s;
      if (fall)     pend_q <= 1'b1;
      else if (clr) pend_q <= 1'b0;
    end
  end

  assign pending = pend_q;

endmodule

`default_nettype wire

// File: rtl/cpu6502_status.sv
// ============================================================================
// Module  : cpu6502_status
// Purpose : 6502 processor status register P with write-priority mux, push
//           image generation, IRQ mask sampling and the interrupt request
//           FSM towards the sequencer.
// Ports   : clk, reset (async active-low)
//           alu_valid/alu_nzcv/alu_mask  ALU flag update
//           db_load/db_in                PLP/RTI load
//           sc_op/sc_bit/sc_val          single-flag set/clear
//           push_brk                     B bit of push image
//           insn_done                    instruction boundary
//           irq, nmi                     active-low interrupt pins
//           int_ack                      sequencer accepted request
//           flags, push_image, dec_mode, int_req, int_nmi  outputs
// Params  : RESET_P (bits 5:4 forced 0), NMI_SYNC
// Config  : CPU6502_DECIMAL_EN defined drives dec_mode from D; otherwise
//           dec_mode is tied 0 while D is still stored and pushed.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module cpu6502_status
  import cpu6502_status_pkg::*;
#(
  parameter logic [7:0] RESET_P  = 8'h00,
  parameter int         NMI_SYNC = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       alu_valid,
  input  logic [3:0] alu_nzcv,
  input  logic [3:0] alu_mask,
  input  logic       db_load,
  input  logic [7:0] db_in,
  input  logic       sc_op,
  input  logic [2:0] sc_bit,
  input  logic       sc_val,
  input  logic       push_brk,
  input  logic       insn_done,
  input  logic       irq,
  input  logic       nmi,
  input  logic       int_ack,
  output logic [7:0] flags,
  output logic [7:0] push_image,
  output logic       dec_mode,
  output logic       int_req,
  output logic       int_nmi
);

  logic [7:0] p_q, p_d;
  int_state_t state_q, state_d;
  logic       int_nmi_q, int_nmi_d;
  logic       i_sampled_q;
  logic       nmi_pending;
  logic       ack_accept;

  // An ack only means something while a request is outstanding.
  assign ack_accept = (state_q == ST_REQ) & int_ack;

  cpu6502_nmi_detect #(
    .NMI_SYNC (NMI_SYNC)
  ) u_nmi_detect (
    .clk     (clk),
    .reset   (reset),
    .nmi     (nmi),
    .clr     (ack_accept & int_nmi_q),
    .pending (nmi_pending)
  );

  // P next-state: db_load > sc_op > alu_valid; interrupt entry forces I last.
  always_comb begin
    p_d = p_q;
    if (db_load) begin
      p_d = db_in;
    end else if (sc_op) begin
      if (sc_bit != 3'(FLAG_B) && sc_bit != 3'(FLAG_U))
        p_d[sc_bit] = sc_val;
    end else if (alu_valid) begin
      p_d = alu_merge(p_q, alu_nzcv, alu_mask);
    end
    if (ack_accept) p_d[FLAG_I] = 1'b1;
    p_d = p_d & P_STORED_MASK;
  end

  // Request FSM: NMI beats IRQ; IRQ uses the I value latched at the
  // previous boundary, so CLI/SEI/PLP act one instruction late.
  always_comb begin
    state_d   = state_q;
    int_nmi_d = int_nmi_q;
    case (state_q)
      ST_IDLE: begin
        if (insn_done && (nmi_pending || (!irq && !i_sampled_q))) begin
          state_d   = ST_REQ;
          int_nmi_d = nmi_pending;
        end
      end
      ST_REQ: begin
        if (int_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_q         <= RESET_P & P_STORED_MASK;
      state_q     <= ST_IDLE;
      int_nmi_q   <= 1'b0;
      i_sampled_q <= 1'b1;
    end else begin
      p_q       <= p_d;
      state_q   <= state_d;
      int_nmi_q <= int_nmi_d;
      if (insn_done) i_sampled_q <= p_q[FLAG_I];
    end
  end

  assign flags      = p_q;
  assign push_image = p_q | 8'h20 | (push_brk ? 8'h10 : 8'h00);
  assign int_req    = (state_q == ST_REQ);
  assign int_nmi    = int_nmi_q;

`ifdef CPU6502_DECIMAL_EN
  assign dec_mode = p_q[FLAG_D];
`else
  assign dec_mode = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cpu6502_status.sv
// ============================================================================
// Module  : tb_cpu6502_status
// Purpose : Self-checking bench for cpu6502_status (default parameters).
//           Directed scenarios followed by randomized traffic, all outputs
//           compared every cycle against a behavioural model of P and the
//           interrupt logic.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cpu6502_status;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       alu_valid = 1'b0;
  logic [3:0] alu_nzcv = 4'h0;
  logic [3:0] alu_mask = 4'h0;
  logic       db_load = 1'b0;
  logic [7:0] db_in = 8'h00;
  logic       sc_op = 1'b0;
  logic [2:0] sc_bit = 3'd0;
  logic       sc_val = 1'b0;
  logic       push_brk = 1'b0;
  logic       insn_done = 1'b0;
  logic       irq = 1'b1;
  logic       nmi = 1'b1;
  logic       int_ack = 1'b0;
  logic [7:0] flags, push_image;
  logic       dec_mode, int_req, int_nmi;

  always #5 clk = ~clk;

  cpu6502_status dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_nzcv(alu_nzcv), .alu_mask(alu_mask),
    .db_load(db_load), .db_in(db_in),
    .sc_op(sc_op), .sc_bit(sc_bit), .sc_val(sc_val),
    .push_brk(push_brk), .insn_done(insn_done),
    .irq(irq), .nmi(nmi), .int_ack(int_ack),
    .flags(flags), .push_image(push_image), .dec_mode(dec_mode),
    .int_req(int_req), .int_nmi(int_nmi)
  );

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  // Reference model state
  logic [7:0] m_p;
  bit         m_req, m_nmi, m_pend, m_isamp;
  bit         nmi_hist[$];   // nmi sampled at past edges, newest at back

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_p    = 8'h00;
    m_req  = 0;
    m_nmi  = 0;
    m_pend = 0;
    m_isamp = 1;
    nmi_hist = '{1'b1, 1'b1, 1'b1};
  endtask

  // One rising edge of the architectural behaviour, using pre-edge values.
  task automatic model_step();
    logic [7:0] np;
    bit accept, fall, pend_now;
    int sz;
    sz = nmi_hist.size();
    // Synchronised pin lags two edges; falling edge seen one edge later.
    fall = nmi_hist[sz-3] && !nmi_hist[sz-2];
    accept = m_req && int_ack;
    pend_now = m_pend;
    np = m_p;
    if (db_load) np = db_in;
    else if (sc_op) begin
      if (sc_bit != 3'd4 && sc_bit != 3'd5) np[sc_bit] = sc_val;
    end else if (alu_valid) begin
      if (alu_mask[3]) np[7] = alu_nzcv[3];
      if (alu_mask[2]) np[1] = alu_nzcv[2];
      if (alu_mask[1]) np[0] = alu_nzcv[1];
      if (alu_mask[0]) np[6] = alu_nzcv[0];
    end
    if (accept) np[2] = 1'b1;
    np = np & 8'hCF;
    if (fall) m_pend = 1;
    else if (accept && m_nmi) m_pend = 0;
    if (insn_done) m_isamp = m_p[2];
    if (!m_req) begin
      if (insn_done && (pend_now || (!irq && !m_isamp_prev_dummy(m_isamp, insn_done)))) begin
        m_req = 1;
        m_nmi = pend_now;
      end
    end else if (int_ack) begin
      m_req = 0;
    end
    m_p = np;
    nmi_hist.push_back(nmi);
    void'(nmi_hist.pop_front());
  endtask

  // The request decision uses the mask sampled at the previous boundary;
  // model_step updates m_isamp first, so recover the prior value here.
  bit isamp_before;
  function automatic bit m_isamp_prev_dummy(input bit cur, input bit done);
    return done ? isamp_before : cur;
  endfunction

  task automatic check_all(input string tag);
    logic [7:0] exp_push;
    exp_push = m_p | 8'h20 | (push_brk ? 8'h10 : 8'h00);
    check({tag, ".flags"}, flags, m_p);
    check({tag, ".push"}, push_image, exp_push);
    check({tag, ".req"}, {7'd0, int_req}, {7'd0, m_req});
    if (m_req) check({tag, ".nmi"}, {7'd0, int_nmi}, {7'd0, m_nmi});
`ifdef CPU6502_DECIMAL_EN
    check({tag, ".dec"}, {7'd0, dec_mode}, {7'd0, m_p[3]});
`else
    check({tag, ".dec"}, {7'd0, dec_mode}, 8'h00);
`endif
  endtask

  task automatic clear_strobes();
    alu_valid = 0; db_load = 0; sc_op = 0; insn_done = 0; int_ack = 0;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    isamp_before = m_isamp;
    model_step();
    #1;
    check_all(tag);
    clear_strobes();
  endtask

  initial begin
    model_reset();
    #2;
    check("rst0.flags", flags, 8'h00);
    check("rst0.req", {7'd0, int_req}, 8'h00);
    @(negedge clk);
    reset = 1;

    // Reset mid-run: outputs clear without a clock edge
    db_load = 1; db_in = 8'hC3;
    tick("t1.load");
    check("t1.preset", flags, 8'hC3);
    #2 reset = 0;
    #1;
    check("t1.async_flags", flags, 8'h00);
    check("t1.async_req", {7'd0, int_req}, 8'h00);
    model_reset();
    @(negedge clk);
    reset = 1;

    // ALU masked update
    db_load = 1; db_in = 8'h40;
    tick("t2.load");
    alu_valid = 1; alu_nzcv = 4'b0010; alu_mask = 4'b1110;
    tick("t2.alu");
    check("t2.cmp", flags, 8'h41);

    // PLP of FF and push images
    db_load = 1; db_in = 8'hFF;
    tick("t3.load");
    check("t3.flags", flags, 8'hCF);
    push_brk = 1; #1;
    check("t3.push_brk", push_image, 8'hFF);
    push_brk = 0; #1;
    check("t3.push_irq", push_image, 8'hEF);

    // CLI takes effect for IRQ one boundary late
    irq = 0;
    sc_op = 1; sc_bit = 3'd2; sc_val = 0;
    tick("t4.cli");
    insn_done = 1;
    tick("t4.done1");
    check("t4.noreq", {7'd0, int_req}, 8'h00);
    insn_done = 1;
    tick("t4.done2");
    check("t4.req", {7'd0, int_req}, 8'h01);
    check("t4.irqsel", {7'd0, int_nmi}, 8'h00);
    int_ack = 1;
    tick("t4.ack");
    check("t4.ack_req", {7'd0, int_req}, 8'h00);
    check("t4.ack_i", {7'd0, flags[2]}, 8'h01);
    irq = 1;

    // NMI beats IRQ, IRQ follows at the next boundary
    sc_op = 1; sc_bit = 3'd2; sc_val = 0;
    tick("t5.cli");
    insn_done = 1;
    tick("t5.sample");
    irq = 0; nmi = 0;
    for (int i = 0; i < 4; i++) tick("t5.sync");
    insn_done = 1;
    tick("t5.done");
    check("t5.nmi_req", {6'd0, int_req, int_nmi}, 8'h03);
    int_ack = 1;
    tick("t5.ack");
    nmi = 1;
    insn_done = 1;
    tick("t5.done2");
    check("t5.irq_req", {6'd0, int_req, int_nmi}, 8'h02);
    int_ack = 1;
    tick("t5.ack2");
    irq = 1;

    // SED
    db_load = 1; db_in = 8'h00;
    tick("t6.clr");
    sc_op = 1; sc_bit = 3'd3; sc_val = 1;
    tick("t6.sed");
    check("t6.flags", flags, 8'h08);
`ifdef CPU6502_DECIMAL_EN
    check("t6.dec", {7'd0, dec_mode}, 8'h01);
`else
    check("t6.dec", {7'd0, dec_mode}, 8'h00);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      alu_valid = ($urandom_range(0, 2) == 0);
      alu_nzcv  = 4'($urandom);
      alu_mask  = 4'($urandom);
      db_load   = ($urandom_range(0, 5) == 0);
      db_in     = 8'($urandom);
      sc_op     = ($urandom_range(0, 3) == 0);
      sc_bit    = 3'($urandom);
      sc_val    = 1'($urandom);
      push_brk  = 1'($urandom);
      insn_done = ($urandom_range(0, 3) == 0);
      int_ack   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) irq = ~irq;
      if ($urandom_range(0, 7) == 0) nmi = ~nmi;
      tick("rnd");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
